// File: rtl/planta_envase_pkg.sv
// Shared types for the bottling-line plant model: station states, protocol
// error bit positions and the counter-width helper.
package planta_envase_pkg;

  typedef enum logic [2:0] {
    S_TRANSP_ENCH,
    S_ENCH,
    S_TRANSP_CQ,
    S_CQ,
    S_SAIDA
  } estado_t;

  localparam int unsigned ERR_VALVULA_FORA       = 0;
  localparam int unsigned ERR_ESTEIRA_VALVULA    = 1;
  localparam int unsigned ERR_VEDACAO            = 2;
  localparam int unsigned ERR_TRANSBORDO         = 3;
  localparam int unsigned ERR_SAIDA_SEM_VEREDITO = 4;
  localparam int unsigned N_ERR                  = 5;

  function automatic int unsigned largura_cnt(input int unsigned max_ticks);
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/planta_envase_if.sv
// Controller/plant bundle: actuator commands flow master->slave, sensors and
// counters flow slave->master. The plant model is the slave side.
interface planta_envase_if;

  logic       esteira;
  logic       valvula_ativa;
  logic       vedacao_ativa;
  logic       descarte_ativo;

  logic       sensor_posicao_enchimento;
  logic       sensor_nivel;
  logic       sensor_posicao_cq;
  logic       aprovado;
  logic       reprovado;
  logic       garrafa_saida;
  logic [7:0] garrafas_saidas;
  logic [7:0] garrafas_descartadas;
  logic [4:0] erro_protocolo;

  modport master (
    output esteira, valvula_ativa, vedacao_ativa, descarte_ativo,
    input  sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq,
           aprovado, reprovado, garrafa_saida, garrafas_saidas,
           garrafas_descartadas, erro_protocolo
  );

  modport slave (
    input  esteira, valvula_ativa, vedacao_ativa, descarte_ativo,
    output sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq,
           aprovado, reprovado, garrafa_saida, garrafas_saidas,
           garrafas_descartadas, erro_protocolo
  );

endinterface

// File: rtl/planta_envase_sim_contador_transporte.sv
// Enable-gated modulo-TICKS counter; tc strobes on the enabled cycle that
// wraps the count back to zero.
module contador_transporte #(
  parameter int unsigned TICKS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tc
);

  import planta_envase_pkg::*;

  localparam int unsigned W = largura_cnt(TICKS);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = en && (cnt_q == W'(TICKS - 1));
    cnt_d = cnt_q;
    if (tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/planta_envase_sim.sv
// Behavioural plant for the wine bottling line, tracking one bottle through
// fill, QC and exit. Optional protocol monitor: define PLANTA_MONITOR_EN.
module planta_envase_sim #(
  parameter int unsigned TICKS_TRANSPORTE = 100,
  parameter int unsigned TICKS_ENCHIMENTO = 50,
  parameter int unsigned TICKS_CQ         = 20,
  parameter logic [7:0]  PADRAO_CQ        = 8'b0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  planta_envase_if.slave bus
);

  import planta_envase_pkg::*;

  localparam int unsigned WN = largura_cnt(TICKS_ENCHIMENTO);
  localparam int unsigned WC = largura_cnt(TICKS_CQ);

  estado_t       state_q, state_d;
  logic [WN-1:0] nivel_q, nivel_d;
  logic [WC-1:0] cq_q, cq_d;
  logic          vedada_q, vedada_d;
  logic          aprovado_q, aprovado_d;
  logic          reprovado_q, reprovado_d;
  logic [2:0]    idx_q, idx_d;
  logic          saida_q, saida_d;
  logic [7:0]    saidas_q, saidas_d;
  logic [7:0]    descartadas_q, descartadas_d;

  logic          em_transporte;
  logic          pos_en;
  logic          pos_tc;
  logic          nivel_cheio;

  assign em_transporte = (state_q == S_TRANSP_ENCH) || (state_q == S_TRANSP_CQ) ||
                         (state_q == S_SAIDA);
  assign pos_en        = bus.esteira && em_transporte;
  assign nivel_cheio   = (nivel_q == WN'(TICKS_ENCHIMENTO));

  // pos_cnt only runs in transport states and always wraps to 0 on advance,
  // so it is already 0 whenever a new transport leg starts.
  contador_transporte #(
    .TICKS (TICKS_TRANSPORTE)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .en    (pos_en),
    .tc    (pos_tc)
  );

  always_comb begin
    state_d       = state_q;
    nivel_d       = nivel_q;
    cq_d          = cq_q;
    vedada_d      = vedada_q;
    aprovado_d    = aprovado_q;
    reprovado_d   = reprovado_q;
    idx_d         = idx_q;
    saida_d       = 1'b0;
    saidas_d      = saidas_q;
    descartadas_d = descartadas_q;

    unique case (state_q)
      S_TRANSP_ENCH: begin
        if (pos_tc) state_d = S_ENCH;
      end
      S_ENCH: begin
        if (bus.vedacao_ativa && nivel_cheio) vedada_d = 1'b1;
        if (bus.esteira) begin
          state_d = S_TRANSP_CQ;
        end else if (bus.valvula_ativa && !nivel_cheio) begin
          nivel_d = nivel_q + 1'b1;
        end
      end
      S_TRANSP_CQ: begin
        if (pos_tc) state_d = S_CQ;
      end
      S_CQ: begin
        if (bus.descarte_ativo) begin
          state_d       = S_TRANSP_ENCH;
          descartadas_d = descartadas_q + 1'b1;
          vedada_d      = 1'b0;
          aprovado_d    = 1'b0;
          reprovado_d   = 1'b0;
          nivel_d       = '0;
          cq_d          = '0;
        end else if (bus.esteira) begin
          state_d     = S_SAIDA;
          aprovado_d  = 1'b0;
          reprovado_d = 1'b0;
          cq_d        = '0;
        end else begin
          // cq_cnt parks at TICKS_CQ so the verdict latches exactly once.
          if (cq_q == WC'(TICKS_CQ - 1)) begin
            reprovado_d = !vedada_q || PADRAO_CQ[idx_q];
            aprovado_d  = !reprovado_d;
            idx_d       = idx_q + 1'b1;
          end
          if (cq_q != WC'(TICKS_CQ)) cq_d = cq_q + 1'b1;
        end
      end
      S_SAIDA: begin
        if (pos_tc) begin
          state_d  = S_TRANSP_ENCH;
          saida_d  = 1'b1;
          saidas_d = saidas_q + 1'b1;
          nivel_d  = '0;
          vedada_d = 1'b0;
        end
      end
      default: state_d = S_TRANSP_ENCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_TRANSP_ENCH;
      nivel_q       <= '0;
      cq_q          <= '0;
      vedada_q      <= 1'b0;
      aprovado_q    <= 1'b0;
      reprovado_q   <= 1'b0;
      idx_q         <= '0;
      saida_q       <= 1'b0;
      saidas_q      <= '0;
      descartadas_q <= '0;
    end else begin
      state_q       <= state_d;
      nivel_q       <= nivel_d;
      cq_q          <= cq_d;
      vedada_q      <= vedada_d;
      aprovado_q    <= aprovado_d;
      reprovado_q   <= reprovado_d;
      idx_q         <= idx_d;
      saida_q       <= saida_d;
      saidas_q      <= saidas_d;
      descartadas_q <= descartadas_d;
    end
  end

  assign bus.sensor_posicao_enchimento = (state_q == S_ENCH);
  assign bus.sensor_posicao_cq         = (state_q == S_CQ);
  assign bus.sensor_nivel              = nivel_cheio;
  assign bus.aprovado                  = aprovado_q;
  assign bus.reprovado                 = reprovado_q;
  assign bus.garrafa_saida             = saida_q;
  assign bus.garrafas_saidas           = saidas_q;
  assign bus.garrafas_descartadas      = descartadas_q;

`ifdef PLANTA_MONITOR_EN
  logic [N_ERR-1:0] erro_q, erro_d;

  always_comb begin
    erro_d = erro_q;
    if (bus.valvula_ativa && (state_q != S_ENCH))
      erro_d[ERR_VALVULA_FORA] = 1'b1;
    if (bus.esteira && bus.valvula_ativa)
      erro_d[ERR_ESTEIRA_VALVULA] = 1'b1;
    if (bus.vedacao_ativa && ((state_q != S_ENCH) || !nivel_cheio))
      erro_d[ERR_VEDACAO] = 1'b1;
    if (bus.valvula_ativa && nivel_cheio)
      erro_d[ERR_TRANSBORDO] = 1'b1;
    if ((state_q == S_CQ) && !(aprovado_q || reprovado_q) &&
        (bus.descarte_ativo || bus.esteira))
      erro_d[ERR_SAIDA_SEM_VEREDITO] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      erro_q <= '0;
    end else begin
      erro_q <= erro_d;
    end
  end

  assign bus.erro_protocolo = erro_q;
`else
  assign bus.erro_protocolo = '0;
`endif

endmodule

// File: tb/tb_planta_envase_sim.sv
// Closed-loop bench for planta_envase_sim: directed test-plan scenarios then
// randomized controller behaviour, all checked against a bottle-level model.
module tb_planta_envase_sim;

  localparam int unsigned TT  = 4;
  localparam int unsigned TE  = 3;
  localparam int unsigned TC  = 2;
  localparam logic [7:0]  PAD = 8'b0000_0010;

  // bottle location in the model
  localparam int A_CAMINHO_ENCH = 0;
  localparam int NA_ENCHEDORA   = 1;
  localparam int A_CAMINHO_CQ   = 2;
  localparam int NO_CQ          = 3;
  localparam int A_CAMINHO_FIM  = 4;

  logic clk = 1'b0;
  logic reset;
  planta_envase_if bus ();

  planta_envase_sim #(
    .TICKS_TRANSPORTE (TT),
    .TICKS_ENCHIMENTO (TE),
    .TICKS_CQ         (TC),
    .PADRAO_CQ        (PAD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_testes = 0;
  int n_falhas = 0;

  // model state
  int         m_local, m_andado, m_nivel, m_idade_cq, m_veredito; // 0 none,1 ok,2 reject
  bit         m_selada, m_pulso;
  int         m_inspecionadas, m_saidas, m_descartadas;
  logic [4:0] m_erro;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_reset();
    m_local = A_CAMINHO_ENCH; m_andado = 0; m_nivel = 0; m_idade_cq = 0;
    m_veredito = 0; m_selada = 0; m_pulso = 0; m_inspecionadas = 0;
    m_saidas = 0; m_descartadas = 0; m_erro = '0;
  endtask

  task automatic modelo_passo(input bit r, input bit e, input bit v, input bit s, input bit d);
    bit cheio;
    if (r) begin
      modelo_reset();
      return;
    end
    cheio   = (m_nivel == TE);
    m_pulso = 0;
    if (v && m_local != NA_ENCHEDORA) m_erro[0] = 1'b1;
    if (e && v) m_erro[1] = 1'b1;
    if (s && (m_local != NA_ENCHEDORA || !cheio)) m_erro[2] = 1'b1;
    if (v && cheio) m_erro[3] = 1'b1;
    if (m_local == NO_CQ && m_veredito == 0 && (d || e)) m_erro[4] = 1'b1;

    if (m_local == NA_ENCHEDORA) begin
      if (s && cheio) m_selada = 1;
      if (e) m_local = A_CAMINHO_CQ;
      else if (v && !cheio) m_nivel++;
    end else if (m_local == NO_CQ) begin
      if (d) begin
        m_descartadas++;
        m_local = A_CAMINHO_ENCH; m_nivel = 0; m_selada = 0;
        m_veredito = 0; m_idade_cq = 0;
      end else if (e) begin
        m_local = A_CAMINHO_FIM; m_veredito = 0; m_idade_cq = 0;
      end else begin
        if (m_veredito == 0 && m_idade_cq == TC - 1) begin
          m_veredito = (!m_selada || PAD[m_inspecionadas % 8]) ? 2 : 1;
          m_inspecionadas++;
        end
        m_idade_cq++;
      end
    end else if (e) begin
      m_andado++;
      if (m_andado == TT) begin
        m_andado = 0;
        if (m_local == A_CAMINHO_ENCH) m_local = NA_ENCHEDORA;
        else if (m_local == A_CAMINHO_CQ) m_local = NO_CQ;
        else begin
          m_local = A_CAMINHO_ENCH; m_saidas++; m_pulso = 1;
          m_nivel = 0; m_selada = 0;
        end
      end
    end
  endtask

  task automatic compara_modelo();
    logic [4:0] erro_esp;
`ifdef PLANTA_MONITOR_EN
    erro_esp = m_erro;
`else
    erro_esp = '0;
`endif
    verifica("sensores",
             {26'd0, bus.sensor_posicao_enchimento, bus.sensor_nivel, bus.sensor_posicao_cq,
              bus.aprovado, bus.reprovado, bus.garrafa_saida},
             {26'd0, m_local == NA_ENCHEDORA, m_nivel == TE, m_local == NO_CQ,
              m_veredito == 1, m_veredito == 2, m_pulso});
    verifica("contagens", {16'd0, bus.garrafas_saidas, bus.garrafas_descartadas},
             {16'd0, 8'(m_saidas), 8'(m_descartadas)});
    verifica("erro_protocolo", {27'd0, bus.erro_protocolo}, {27'd0, erro_esp});
  endtask

  // check previous edge's result, then apply inputs for the next edge
  task automatic ciclo(input bit r, input bit e, input bit v, input bit s, input bit d);
    @(negedge clk);
    compara_modelo();
    reset = r; bus.esteira = e; bus.valvula_ativa = v;
    bus.vedacao_ativa = s; bus.descarte_ativo = d;
    modelo_passo(r, e, v, s, d);
  endtask

  task automatic repete(input int n, input bit e, input bit v, input bit s, input bit d);
    for (int i = 0; i < n; i++) ciclo(1'b0, e, v, s, d);
  endtask

  task automatic apos_borda();
    @(posedge clk);
    #1;
  endtask

  task automatic ciclo_aleatorio();
    bit r, e, v, s, d;
    r = ($urandom_range(0, 499) == 0);
    e = 0; v = 0; s = 0; d = 0;
    if ($urandom_range(0, 19) == 0) begin
      e = $urandom_range(0, 1); v = $urandom_range(0, 1);
      s = $urandom_range(0, 1); d = $urandom_range(0, 1);
    end else if (m_local == NA_ENCHEDORA) begin
      if (m_nivel < TE) begin
        v = ($urandom_range(0, 4) != 0);
        e = ($urandom_range(0, 11) == 0);
        s = ($urandom_range(0, 9) == 0);
      end else begin
        s = ($urandom_range(0, 2) == 0);
        e = ($urandom_range(0, 3) == 0);
      end
    end else if (m_local == NO_CQ) begin
      if (m_veredito == 0) begin
        e = ($urandom_range(0, 9) == 0);
        d = ($urandom_range(0, 14) == 0);
      end else begin
        d = ($urandom_range(0, 2) == 0);
        e = ($urandom_range(0, 2) == 0);
      end
    end else begin
      e = ($urandom_range(0, 3) != 0);
    end
    // leaving QC on the very verdict cycle is left out of the random mix
    if (m_local == NO_CQ && m_veredito == 0 && m_idade_cq == TC - 1) begin
      e = 0; d = 0;
    end
    ciclo(r, e, v, s, d);
  endtask

  initial begin
    reset = 1'b1;
    bus.esteira = 0; bus.valvula_ativa = 0; bus.vedacao_ativa = 0; bus.descarte_ativo = 0;
    modelo_reset();
    repeat (2) @(posedge clk);

    // 1: transport to filler with a 2-cycle motor gap
    ciclo(1'b1, 0, 0, 0, 0);
    repete(2, 1, 0, 0, 0);
    repete(2, 0, 0, 0, 0);
    repete(1, 1, 0, 0, 0);
    apos_borda();
    verifica("ench_antes", bus.sensor_posicao_enchimento, 1'b0);
    repete(1, 1, 0, 0, 0);
    apos_borda();
    verifica("ench_chegou", bus.sensor_posicao_enchimento, 1'b1);

    // 2: fill to level, then overfill
    repete(3, 0, 1, 0, 0);
    apos_borda();
    verifica("nivel_cheio", bus.sensor_nivel, 1'b1);
    repete(1, 0, 1, 0, 0);
    apos_borda();
`ifdef PLANTA_MONITOR_EN
    verifica("erro_transbordo", bus.erro_protocolo, 5'b01000);
`else
    verifica("erro_transbordo", bus.erro_protocolo, 5'b00000);
`endif

    // 3: seal, to QC, approve, exit
    repete(1, 0, 0, 1, 0);
    repete(5, 1, 0, 0, 0);
    apos_borda();
    verifica("cq_chegou", bus.sensor_posicao_cq, 1'b1);
    repete(2, 0, 0, 0, 0);
    apos_borda();
    verifica("aprovado_1", bus.aprovado, 1'b1);
    repete(5, 1, 0, 0, 0);
    apos_borda();
    verifica("saida_pulso", bus.garrafa_saida, 1'b1);
    verifica("saidas_1", bus.garrafas_saidas, 8'd1);
    verifica("aprovado_limpo", bus.aprovado, 1'b0);

    // 4: sealed bottle rejected by pattern bit1, discarded
    repete(4, 1, 0, 0, 0);
    repete(3, 0, 1, 0, 0);
    repete(1, 0, 0, 1, 0);
    repete(5, 1, 0, 0, 0);
    repete(2, 0, 0, 0, 0);
    apos_borda();
    verifica("reprovado_padrao", bus.reprovado, 1'b1);
    repete(1, 0, 0, 0, 1);
    apos_borda();
    verifica("descartadas_1", bus.garrafas_descartadas, 8'd1);
    verifica("sensores_zero",
             {bus.sensor_posicao_enchimento, bus.sensor_nivel, bus.sensor_posicao_cq,
              bus.aprovado, bus.reprovado}, 5'b00000);

    // 5: unsealed bottle rejected, discard beats conveyor
    repete(4, 1, 0, 0, 0);
    repete(3, 0, 1, 0, 0);
    repete(5, 1, 0, 0, 0);
    repete(2, 0, 0, 0, 0);
    apos_borda();
    verifica("reprovado_sem_selo", bus.reprovado, 1'b1);
    repete(1, 1, 0, 0, 1);
    apos_borda();
    verifica("descartadas_2", bus.garrafas_descartadas, 8'd2);
    verifica("descarte_vence", {bus.sensor_posicao_cq, bus.garrafa_saida}, 2'b00);

    // 6: reset mid-fill
    repete(4, 1, 0, 0, 0);
    repete(2, 0, 1, 0, 0);
    ciclo(1'b1, 0, 0, 0, 0);
    apos_borda();
    verifica("reset_saidas", {bus.garrafas_saidas, bus.garrafas_descartadas}, 16'd0);
    verifica("reset_ench", bus.sensor_posicao_enchimento, 1'b0);
    repete(4, 1, 0, 0, 0);
    repete(2, 0, 1, 0, 0);
    apos_borda();
    verifica("nivel_parcial", bus.sensor_nivel, 1'b0);
    repete(1, 0, 1, 0, 0);
    apos_borda();
    verifica("nivel_recheio", bus.sensor_nivel, 1'b1);

    // randomized closed-loop run
    for (int i = 0; i < 4000; i++) ciclo_aleatorio();
    @(negedge clk);
    compara_modelo();

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
